ifu_fetch: RTL and testbench

Instruction-fetch front end that sits directly upstream of ctrl. It owns the architectural fetch PC and issues in-order 32-bit instruction reads over a valid/ready request channel. It buffers returned words with their PCs and presents pcF/instF to decode. It consumes ctrl's jump/jAddr/flushF/stallF and discards stale in-flight fetches after any redirect.

---
 rtl/ifu_fetch.sv | 135 +++++++++++++
 tb/tb_ifu_fetch.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Purpose : instruction-fetch front end; owns the fetch PC, issues in-order word reads, buffers returned words and presents them to decode.
// Latency : first validF 2 cycles after the fetch stream (re)starts with a ready bus and 1-cycle responses; 1 instr/cycle in steady state.
// Backpressure: ifu_req_valid drops when the buffer is full or stale responses are outstanding; stallF holds pcF/instF and suppresses the pop.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   jump, jAddr       redirect request and target from ctrl
//   flushF            discard every fetched and in-flight instruction
//   stallF            hold decode-facing outputs, no pop
//   ifu_req_*         read request channel (valid/ready, word-aligned addr)
//   ifu_rsp_*         in-order read data, no backpressure
//   validF/pcF/instF  instruction presented to decode (0 / nop when invalid)
//   fetch_busy        entries allocated or stale responses still expected
module ifu_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump,
  input  logic [63:0] jAddr,
  input  logic        flushF,
  input  logic        stallF,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  output logic [63:0] ifu_req_addr,
  input  logic        ifu_rsp_valid,
  input  logic [31:0] ifu_rsp_data,
  output logic        validF,
  output logic [63:0] pcF,
  output logic [31:0] instF,
  output logic        fetch_busy
);

  localparam int          AW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int          CW  = $clog2(BUF_DEPTH) + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // architectural fetch PC
  logic [63:0]    pc_q;
  // request shown on the bus but not yet accepted; stale once a redirect hit it
  logic           hold_q;
  logic           stale_q;
  logic [63:0]    stale_addr_q;
  // circular buffer: head (oldest allocated), tail (next alloc), fill (oldest unfilled)
  logic [AW-1:0]  hd_q, tl_q, fp_q;
  logic [CW-1:0]  cnt_q;   // allocated entries
  logic [CW-1:0]  ufc_q;   // allocated but not yet filled (= live in-flight)
  logic [CW-1:0]  drop_q;  // in-flight responses that must be discarded
  logic [BUF_DEPTH-1:0] buf_filled;
  logic [63:0]    buf_pc   [BUF_DEPTH];
  logic [31:0]    buf_inst [BUF_DEPTH];

  logic redir, full, space, acc, acc_new, acc_drop;
  logic rsp_drop, rsp_take, rsp_fill, pop;

  always_comb begin
    redir    = jump | flushF;
    full     = (cnt_q == CW'(BUF_DEPTH));
    validF   = (cnt_q != '0) & buf_filled[hd_q] & ~redir;
    pop      = validF & ~stallF;
    // a pop frees a slot this cycle, so a full buffer can still accept
    space    = ~full | pop;
    // fresh requests wait until all stale responses have drained
    ifu_req_valid = rst & (hold_q | (space & ~redir & (drop_q == '0)));
    ifu_req_addr  = stale_q ? stale_addr_q : pc_q;
    acc      = ifu_req_valid & ifu_req_ready;
    acc_new  = acc & ~redir & ~stale_q;
    acc_drop = acc & ~redir & stale_q;
    rsp_drop = ifu_rsp_valid & (drop_q != '0);
    // responses with nothing outstanding are ignored entirely
    rsp_take = ifu_rsp_valid & ((drop_q != '0) | (ufc_q != '0));
    rsp_fill = ifu_rsp_valid & (drop_q == '0) & (ufc_q != '0) & ~redir;
    pcF      = validF ? buf_pc[hd_q]   : 64'h0;
    instF    = validF ? buf_inst[hd_q] : NOP;
    fetch_busy = (cnt_q != '0) | (drop_q != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      hold_q       <= 1'b0;
      stale_q      <= 1'b0;
      stale_addr_q <= RESET_PC;
      hd_q         <= '0;
      tl_q         <= '0;
      fp_q         <= '0;
      cnt_q        <= '0;
      ufc_q        <= '0;
      drop_q       <= '0;
      buf_filled   <= '0;
    end else begin
      hold_q  <= ifu_req_valid & ~ifu_req_ready;
      // a held request overtaken by a redirect keeps its old address
      stale_q <= ifu_req_valid & ~ifu_req_ready & (stale_q | redir);
      if (!stale_q) stale_addr_q <= pc_q;

      if (redir) begin
        if (jump) pc_q <= jAddr & ~64'h3;
        hd_q       <= '0;
        tl_q       <= '0;
        fp_q       <= '0;
        cnt_q      <= '0;
        ufc_q      <= '0;
        buf_filled <= '0;
        // everything still in flight after this edge becomes a drop
        drop_q <= drop_q + ufc_q + CW'(acc) - CW'(rsp_take);
      end else begin
        if (acc_new) begin
          pc_q             <= pc_q + 64'd4;
          tl_q             <= tl_q + AW'(1);
          buf_filled[tl_q] <= 1'b0;
        end
        if (rsp_fill) begin
          buf_filled[fp_q] <= 1'b1;
          fp_q             <= fp_q + AW'(1);
        end
        if (pop) begin
          buf_filled[hd_q] <= 1'b0;
          hd_q             <= hd_q + AW'(1);
        end
        cnt_q  <= cnt_q + CW'(acc_new) - CW'(pop);
        ufc_q  <= ufc_q + CW'(acc_new) - CW'(rsp_fill);
        drop_q <= drop_q + CW'(acc_drop) - CW'(rsp_drop);
      end
    end
  end

  // payload storage needs no reset: filled bits qualify every read
  always_ff @(posedge clk) begin
    if (acc_new)  buf_pc[tl_q]   <= ifu_req_addr;
    if (rsp_fill) buf_inst[fp_q] <= ifu_rsp_data;
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios then random traffic, every cycle
// compared against a queue-based reference model and an in-order bus model.
module tb_ifu_fetch;
  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;
  localparam int          D   = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, jump, flushF, stallF, ifu_req_ready, ifu_rsp_valid;
  logic [63:0] jAddr, ifu_req_addr, pcF;
  logic [31:0] ifu_rsp_data, instF;
  logic        ifu_req_valid, validF, fetch_busy;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RPC), .BUF_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .jump(jump), .jAddr(jAddr), .flushF(flushF),
    .stallF(stallF), .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
    .ifu_req_addr(ifu_req_addr), .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rsp_data(ifu_rsp_data), .validF(validF), .pcF(pcF), .instF(instF),
    .fetch_busy(fetch_busy));

  // in-flight bus requests in issue order; stale ones will be discarded
  typedef struct { logic [63:0] addr; bit stale; int due; } req_t;
  // allocated fetch-buffer slots in program order
  typedef struct { logic [63:0] pc; bit have; } ent_t;

  req_t        bus[$];
  ent_t        mbuf[$];
  logic [63:0] m_pc, m_hold_addr;
  bit          m_hold, m_hold_stale, rst_drv;
  int          cyc, total, bad, lat_lo, lat_hi, first_vf;
  logic [63:0] acc_log[$], pop_log[$];

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[33:2] ^ 32'hC3A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    bus.delete();
    mbuf.delete();
    m_pc = RPC;
    m_hold = 0;
    m_hold_stale = 0;
    m_hold_addr = RPC;
  endtask

  // one clock cycle: drive, check all outputs, advance the model
  task automatic step(input bit j, input logic [63:0] ja, input bit fl, input bit st, input bit rdy);
    bit redir, exp_v, exp_vf, acc, rsp, done, new_hold;
    logic [63:0] exp_a, exp_pc;
    int nstale;
    req_t r, q;
    ent_t e;
    @(negedge clk);
    rst = rst_drv; jump = j; jAddr = ja; flushF = fl; stallF = st; ifu_req_ready = rdy;
    rsp = rst_drv && bus.size() > 0 && bus[0].due <= cyc;
    ifu_rsp_valid = rsp;
    ifu_rsp_data  = rsp ? word_of(bus[0].addr) : $urandom();
    #1;
    redir  = j | fl;
    nstale = 0;
    foreach (bus[i]) if (bus[i].stale) nstale++;
    exp_vf = mbuf.size() > 0 && mbuf[0].have && !redir;
    exp_pc = exp_vf ? mbuf[0].pc : 64'h0;
    exp_v  = rst_drv && (m_hold || ((mbuf.size() < D || (exp_vf && !st)) && !redir && nstale == 0));
    exp_a  = m_hold ? m_hold_addr : m_pc;
    chk("req_valid", 64'(ifu_req_valid), 64'(exp_v));
    chk("req_addr", ifu_req_addr, exp_a);
    chk("validF", 64'(validF), 64'(exp_vf));
    chk("pcF", pcF, exp_pc);
    chk("instF", 64'(instF), 64'(exp_vf ? word_of(exp_pc) : NOP));
    chk("fetch_busy", 64'(fetch_busy), 64'(mbuf.size() != 0 || nstale != 0));
    if (ifu_req_valid && rdy) acc_log.push_back(ifu_req_addr);
    if (validF && !st) pop_log.push_back(pcF);
    if (validF && first_vf < 0) first_vf = cyc;
    if (rst_drv) begin
      acc = exp_v && rdy;
      if (rsp) r = bus.pop_front();
      q.addr = exp_a;
      q.due  = cyc + 1 + $urandom_range(lat_hi, lat_lo);
      if (redir) begin
        for (int i = 0; i < bus.size(); i++) begin
          q.addr = bus[i].addr; q.due = bus[i].due; q.stale = 1; bus[i] = q;
        end
        q.addr = exp_a; q.due = cyc + 1 + $urandom_range(lat_hi, lat_lo); q.stale = 1;
        if (acc) bus.push_back(q);
        mbuf.delete();
        if (j) m_pc = {ja[63:2], 2'b00};
      end else begin
        if (rsp && !r.stale) begin
          done = 0;
          for (int i = 0; i < mbuf.size(); i++) begin
            if (!done && !mbuf[i].have) begin
              e = mbuf[i]; e.have = 1; mbuf[i] = e; done = 1;
            end
          end
        end
        if (exp_vf && !st) void'(mbuf.pop_front());
        if (acc) begin
          q.stale = m_hold_stale;
          bus.push_back(q);
          if (!m_hold_stale) begin
            e.pc = exp_a; e.have = 0;
            mbuf.push_back(e);
            m_pc = m_pc + 64'd4;
          end
        end
      end
      new_hold     = exp_v && !rdy;
      m_hold_stale = new_hold && (m_hold_stale || redir);
      m_hold       = new_hold;
      m_hold_addr  = exp_a;
    end
    cyc++;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 0;
    rst_drv = 0;
    #1;
    chk("arst_req_valid", 64'(ifu_req_valid), 64'h0);
    chk("arst_req_addr", ifu_req_addr, RPC);
    chk("arst_validF", 64'(validF), 64'h0);
    chk("arst_pcF", pcF, 64'h0);
    chk("arst_instF", 64'(instF), 64'(NOP));
    chk("arst_busy", 64'(fetch_busy), 64'h0);
    model_reset();
  endtask

  initial begin
    logic [63:0] hp, x4, p5_pc;
    int rel, n, np;
    rst = 0; rst_drv = 0; jump = 0; jAddr = '0; flushF = 0; stallF = 0;
    ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_data = '0;
    total = 0; bad = 0; cyc = 0; lat_lo = 0; lat_hi = 0; first_vf = -1;
    model_reset();

    // reset then stream with ready=1 and 1-cycle responses
    repeat (3) step(0, 0, 0, 0, 1);
    rst_drv = 1;
    rel = cyc;
    repeat (12) step(0, 0, 0, 0, 1);
    chk("p1_first_vf_lat", 64'(first_vf - rel), 64'd2);
    chk("p1_n_pops", 64'(pop_log.size()), 64'd10);
    if (acc_log.size() >= 2) begin
      chk("p1_acc0", acc_log[0], RPC);
      chk("p1_acc1", acc_log[1], RPC + 64'd4);
    end

    // stall three cycles with the buffer full
    hp = mbuf[0].pc;
    repeat (3) begin
      step(0, 0, 0, 1, 1);
      chk("p2_hold_pc", pcF, hp);
      chk("p2_hold_inst", 64'(instF), 64'(word_of(hp)));
      chk("p2_no_req", 64'(ifu_req_valid), 64'h0);
    end
    repeat (8) step(0, 0, 0, 0, 1);
    foreach (pop_log[i]) chk("p2_order", pop_log[i], RPC + 64'(4 * i));

    // jump with two requests outstanding (2-cycle responses)
    lat_lo = 1; lat_hi = 1;
    repeat (6) step(0, 0, 0, 0, 1);
    n = acc_log.size(); np = pop_log.size();
    step(1, 64'h8000_0100, 0, 0, 1);
    lat_lo = 0; lat_hi = 0;
    repeat (10) step(0, 0, 0, 0, 1);
    chk("p3_any_acc", 64'(acc_log.size() > n), 64'd1);
    chk("p3_any_pop", 64'(pop_log.size() > np), 64'd1);
    if (acc_log.size() > n) chk("p3_next_req", acc_log[n], 64'h8000_0100);
    if (pop_log.size() > np) chk("p3_first_pc", pop_log[np], 64'h8000_0100);

    // request held 4 cycles with ready=0, then jump
    repeat (4) step(0, 0, 0, 0, 0);
    chk("p4_pending", 64'(ifu_req_valid), 64'd1);
    x4 = m_hold_addr;
    n = acc_log.size(); np = pop_log.size();
    step(1, 64'h8000_0200, 0, 0, 0);
    repeat (10) step(0, 0, 0, 0, 1);
    chk("p4_n_acc", 64'(acc_log.size() >= n + 2), 64'd1);
    if (acc_log.size() >= n + 2) begin
      chk("p4_old_addr", acc_log[n], x4);
      chk("p4_new_addr", acc_log[n + 1], 64'h8000_0200);
    end
    if (pop_log.size() > np) chk("p4_first_pc", pop_log[np], 64'h8000_0200);

    // flush in the same cycle a response lands
    repeat (4) step(0, 0, 0, 0, 1);
    p5_pc = m_pc;
    n = acc_log.size();
    step(0, 64'hdead_beef, 1, 0, 1);
    chk("p5_flush_vf", 64'(validF), 64'h0);
    repeat (6) step(0, 0, 0, 0, 1);
    if (acc_log.size() > n) chk("p5_resume", acc_log[n], p5_pc);

    // asynchronous reset mid-stream
    async_reset();
    repeat (2) step(0, 0, 0, 0, 1);
    rst_drv = 1;
    n = acc_log.size();
    repeat (6) step(0, 0, 0, 0, 1);
    if (acc_log.size() > n) chk("p6_restart", acc_log[n], RPC);

    // random traffic
    lat_lo = 0; lat_hi = 3;
    repeat (500) begin
      step($urandom_range(0, 29) == 0, {$urandom(), $urandom()},
           $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 2,
           $urandom_range(0, 9) < 7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
